vga_cfg_sequencer: RTL and testbench

- Frame-synchronous configuration controller sitting between the board switches/button and the square pattern generator and gray-bypass mux of the VGA demo top level.
- Supports two modes:
  - MANUAL: switches drive the config.
  - AUTO: the block steps through colors, pixel sizes and gray/color mode on its own.
- All config changes are applied only at frame start (hc==0, vc==0) so no frame is torn mid-scan.
- A debounced push button toggles between MANUAL and AUTO.

---
 rtl/vga_cfg_if.sv | 24 ++
 rtl/vga_cfg_sequencer.sv | 146 ++++++++++++++
 tb/tb_vga_cfg_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_cfg_if.sv
// Switch/button/counter inputs and config outputs of the VGA config sequencer.
interface vga_cfg_if #(
   parameter int CD = 12
);
   logic [14:0]   sw;
   logic          btn;
   logic [10:0]   hc;
   logic [10:0]   vc;
   logic [CD-1:0] color_cfg;
   logic [1:0]    pixel_cfg;
   logic          bypass_gray;
   logic          auto_active;
   logic          frame_tick;

   modport master (
      output sw, btn, hc, vc,
      input  color_cfg, pixel_cfg, bypass_gray, auto_active, frame_tick
   );

   modport slave (
      input  sw, btn, hc, vc,
      output color_cfg, pixel_cfg, bypass_gray, auto_active, frame_tick
   );
endinterface

// File: rtl/vga_cfg_sequencer.sv
// Frame-synchronous MANUAL/AUTO config sequencer for the square generator and gray mux.
// Config and frame_tick update on the frame-start edge only; no backpressure (free-running).
module vga_cfg_sequencer #(
   parameter int CD              = 12,
   parameter int DB_CYCLES       = 2_000_000,
   parameter int FRAMES_PER_STEP = 60
) (
   input  logic      clk,
   input  logic      reset_n,
   vga_cfg_if.slave  cfg_if
);
   localparam int DBW = $clog2(DB_CYCLES) + 1;
   localparam int FCW = $clog2(FRAMES_PER_STEP) + 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_e;

   function automatic logic [CD-1:0] palette(input logic [2:0] i);
      return CD'({{4{i[2]}}, {4{i[1]}}, {4{i[0]}}});
   endfunction

   logic [14:0]    sw_s1, sw_s2;
   logic           btn_s1, btn_s2;
   logic [DBW-1:0] db_cnt;
   logic           btn_stable, btn_stable_q;
   logic           fs_raw, fs_raw_q, frame_start, press;

   mode_e          mode_q, mode_d;
   logic           pend_q, pend_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [CD-1:0]  color_q, color_d;
   logic [1:0]     pixel_q, pixel_d;
   logic           bypass_q, bypass_d;
   logic           tick_q, tick_d;

   assign fs_raw      = (cfg_if.hc == 11'd0) && (cfg_if.vc == 11'd0);
   assign frame_start = fs_raw && !fs_raw_q;
   assign press       = btn_stable && !btn_stable_q;

   // The debounce counter measures how long the synced button has disagreed with btn_stable.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sw_s1        <= '0;
         sw_s2        <= '0;
         btn_s1       <= 1'b0;
         btn_s2       <= 1'b0;
         db_cnt       <= '0;
         btn_stable   <= 1'b0;
         btn_stable_q <= 1'b0;
         fs_raw_q     <= 1'b0;
      end else begin
         sw_s1        <= cfg_if.sw;
         sw_s2        <= sw_s1;
         btn_s1       <= cfg_if.btn;
         btn_s2       <= btn_s1;
         btn_stable_q <= btn_stable;
         fs_raw_q     <= fs_raw;
         if (btn_s2 == btn_stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt     <= '0;
            btn_stable <= btn_s2;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_q      <= MANUAL;
         pend_q      <= 1'b0;
         frame_cnt_q <= '0;
         idx_q       <= '0;
         color_q     <= '0;
         pixel_q     <= '0;
         bypass_q    <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         pend_q      <= pend_d;
         frame_cnt_q <= frame_cnt_d;
         idx_q       <= idx_d;
         color_q     <= color_d;
         pixel_q     <= pixel_d;
         bypass_q    <= bypass_d;
         tick_q      <= tick_d;
      end
   end

   always_comb begin
      mode_d      = mode_q;
      pend_d      = pend_q;
      frame_cnt_d = frame_cnt_q;
      idx_d       = idx_q;
      color_d     = color_q;
      pixel_d     = pixel_q;
      bypass_d    = bypass_q;
      tick_d      = 1'b0;

      // A press coinciding with the consuming frame is dropped; otherwise it arms the next frame.
      if (frame_start && pend_q) begin
         pend_d = 1'b0;
      end else if (press) begin
         pend_d = 1'b1;
      end

      if (frame_start) begin
         tick_d = 1'b1;
         if (pend_q && mode_q == MANUAL) begin
            mode_d      = AUTO;
            frame_cnt_d = '0;
            idx_d       = '0;
            pixel_d     = '0;
            bypass_d    = 1'b1;
            color_d     = palette(3'd0);
         end else if (pend_q || mode_q == MANUAL) begin
            mode_d      = MANUAL;
            frame_cnt_d = '0;
            color_d     = CD'(sw_s2[11:0]);
            pixel_d     = sw_s2[13:12];
            bypass_d    = sw_s2[14];
         end else if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            idx_d       = idx_q + 3'd1;
            color_d     = palette(idx_q + 3'd1);
            if (idx_q == 3'd7) begin
               pixel_d = pixel_q + 2'd1;
               if (pixel_q == 2'd3) begin
                  bypass_d = !bypass_q;
               end
            end
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   assign cfg_if.color_cfg   = color_q;
   assign cfg_if.pixel_cfg   = pixel_q;
   assign cfg_if.bypass_gray = bypass_q;
   assign cfg_if.auto_active = (mode_q == AUTO);
   assign cfg_if.frame_tick  = tick_q;
endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// Directed bench for vga_cfg_sequencer with a 48-clk stub frame (hc 0..3, vc 0..2, 4 clks per hc value).
module tb_vga_cfg_sequencer;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   pos = 0;

   vga_cfg_if #(.CD(12)) vif();

   vga_cfg_sequencer #(
      .CD(12),
      .DB_CYCLES(4),
      .FRAMES_PER_STEP(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cfg_if(vif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      vif.hc = 11'd0;
      vif.vc = 11'd0;
      forever begin
         @(negedge clk);
         pos    = (pos == 47) ? 0 : pos + 1;
         vif.hc = 11'((pos / 4) % 4);
         vif.vc = 11'(pos / 16);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cfg(input string tag, input logic [11:0] color, input logic [1:0] pixel,
                          input logic bypass, input logic auto);
      chk({tag, "_color"},  vif.color_cfg,   color);
      chk({tag, "_pixel"},  vif.pixel_cfg,   pixel);
      chk({tag, "_bypass"}, vif.bypass_gray, bypass);
      chk({tag, "_auto"},   vif.auto_active, auto);
   endtask

   task automatic wait_tick(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (vif.frame_tick) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         errors++;
         $error("FAIL %s frame_tick observed=0 expected=1 within 100 clks", tag);
      end
   endtask

   task automatic frames(input int n, input string tag);
      repeat (n) wait_tick(tag);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int len);
      @(negedge clk);
      vif.btn = 1'b1;
      repeat (len) @(negedge clk);
      vif.btn = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      vif.sw  = 15'h7FFF;
      vif.btn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_cfg("reset", 12'h000, 2'd0, 1'b1, 1'b0);
      chk("reset_tick", vif.frame_tick, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      wait_tick("boot");
      wait_tick("boot2");
      chk_cfg("manual_fff", 12'hFFF, 2'd3, 1'b1, 1'b0);

      // Mid-frame switch change must wait for the next frame start.
      cyc(10);
      vif.sw = 15'h5A3C;
      cyc(5);
      chk("tear_hold_color", vif.color_cfg, 12'hFFF);
      chk("tear_hold_pixel", vif.pixel_cfg, 2'd3);
      wait_tick("tear");
      chk_cfg("manual_5a3c", 12'hA3C, 2'd1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("tick_one_clk", vif.frame_tick, 1'b0);

      cyc(4);
      press(2);
      cyc(8);
      press(3);
      cyc(8);
      press(1);
      wait_tick("glitch1");
      chk("glitch1_auto", vif.auto_active, 1'b0);
      wait_tick("glitch2");
      chk("glitch2_auto", vif.auto_active, 1'b0);
      chk("glitch2_color", vif.color_cfg, 12'hA3C);

      cyc(4);
      press(6);
      wait_tick("enter_auto");
      chk_cfg("auto_entry", 12'h000, 2'd0, 1'b1, 1'b1);
      wait_tick("auto_hold");
      chk("auto_hold_color", vif.color_cfg, 12'h000);
      wait_tick("auto_s1");
      chk("auto_step1_color", vif.color_cfg, 12'h00F);
      frames(2, "auto_s2");
      chk("auto_step2_color", vif.color_cfg, 12'h0F0);
      frames(12, "auto_s8");
      chk_cfg("auto_step8", 12'h000, 2'd1, 1'b1, 1'b1);
      frames(48, "auto_s32");
      chk_cfg("auto_step32", 12'h000, 2'd0, 1'b0, 1'b1);

      cyc(2);
      vif.sw = 15'h0123;
      cyc(2);
      press(6);
      wait_tick("to_manual");
      chk_cfg("manual_0123", 12'h123, 2'd0, 1'b0, 1'b0);

      // Time the press so it is recognised on exactly the frame-start edge.
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (pos == 41) break;
      end
      @(negedge clk);
      vif.btn = 1'b1;
      repeat (6) @(negedge clk);
      vif.btn = 1'b0;
      wait_tick("edge_press_frame");
      chk("edge_press_not_yet", vif.auto_active, 1'b0);
      chk("edge_press_color", vif.color_cfg, 12'h123);
      wait_tick("edge_press_next");
      chk("edge_press_applied", vif.auto_active, 1'b1);

      cyc(2);
      press(6);
      cyc(10);
      press(6);
      wait_tick("dbl1");
      chk("dbl_toggle_auto", vif.auto_active, 1'b0);
      chk("dbl_toggle_color", vif.color_cfg, 12'h123);
      wait_tick("dbl2");
      chk("dbl_no_second", vif.auto_active, 1'b0);

      cyc(2);
      press(6);
      wait_tick("re_auto");
      chk("re_auto_active", vif.auto_active, 1'b1);
      frames(4, "re_auto_run");
      chk("pre_reset_color", vif.color_cfg, 12'h0F0);
      cyc(10);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_cfg("mid_reset", 12'h000, 2'd0, 1'b1, 1'b0);
      chk("mid_reset_tick", vif.frame_tick, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_tick("post_reset1");
      wait_tick("post_reset2");
      chk_cfg("post_reset_manual", 12'h123, 2'd0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
